// File: rtl/exu_pkg.sv
// exu_pkg: shared widths, ALU op codes, operand selectors and the pipeline entry type
package exu_pkg;
  localparam int EXU_WIDTH = 32;
  localparam int EXU_REG_AW = 5;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OP_AND  = 4'b1110;
  localparam logic [3:0] ALU_OP_OR   = 4'b1100;
  localparam logic [3:0] ALU_OP_XOR  = 4'b1000;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0010;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1010;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0100;
  localparam logic [3:0] ALU_OP_SLTU = 4'b0110;
  localparam logic SRC1_RS1 = 1'b0;
  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_RS2 = 1'b0;
  localparam logic SRC2_IMM = 1'b1;
  typedef struct packed {
    logic [3:0]            alu_op;
    logic [EXU_WIDTH-1:0]  left;
    logic [EXU_WIDTH-1:0]  right;
    logic [EXU_WIDTH-1:0]  store_data;
    logic [EXU_WIDTH-1:0]  pc;
    logic [EXU_REG_AW-1:0] rd;
    logic                  rd_wen;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/exu_skid_buf.sv
// exu_skid_buf: 2-entry valid/ready skid buffer with a registered in_ready
module exu_skid_buf
  import exu_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  buf_state_t state, state_d;
  T main_q, skid_q;
  logic accept, issue, load_main, load_skid;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  always_comb begin
    accept = in_valid && in_ready;
    issue = out_valid && out_ready;
    state_d = flush ? EMPTY :
              state == EMPTY ? (accept ? ONE : EMPTY) :
              state == ONE ? (accept && !issue ? FULL : !accept && issue ? EMPTY : ONE) :
              (issue ? ONE : FULL);
    load_main = (accept && (state == EMPTY || issue)) || (state == FULL && issue);
    load_skid = state == ONE && accept && !issue;
  end
  // in_ready follows the next state so it never depends combinationally on out_ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_d;
      in_ready <= state_d != FULL;
      if (load_main) main_q <= state == FULL ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
endmodule

// File: rtl/exu_operand_stage.sv
// exu_operand_stage: writeback forwarding and ALU operand selection ahead of a skid buffer
module exu_operand_stage
  import exu_pkg::*;
#(
  parameter int WIDTH = EXU_WIDTH,
  parameter int REG_AW = EXU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_pc,
  input  logic [REG_AW-1:0] in_rs1_idx,
  input  logic [REG_AW-1:0] in_rs2_idx,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              in_src1_sel,
  input  logic              in_src2_sel,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_wen,
  input  logic              fwd_wen,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [WIDTH-1:0]  fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [WIDTH-1:0]  out_left,
  output logic [WIDTH-1:0]  out_right,
  output logic [WIDTH-1:0]  out_store_data,
  output logic [WIDTH-1:0]  out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_wen
);
  logic [WIDTH-1:0] rs1_f, rs2_f;
  entry_t din, dout;
  // x0 is hardwired zero in the regfile, so a write to it must never be forwarded
  always_comb begin
    rs1_f = fwd_wen && fwd_rd != '0 && fwd_rd == in_rs1_idx ? fwd_data : in_rs1_data;
    rs2_f = fwd_wen && fwd_rd != '0 && fwd_rd == in_rs2_idx ? fwd_data : in_rs2_data;
    din.alu_op = in_alu_op;
    din.left = in_src1_sel == SRC1_PC ? in_pc : rs1_f;
    din.right = in_src2_sel == SRC2_IMM ? in_imm : rs2_f;
    din.store_data = rs2_f;
    din.pc = in_pc;
    din.rd = in_rd;
    din.rd_wen = in_rd_wen;
  end
  exu_skid_buf #(.T(entry_t)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(dout)
  );
  assign out_alu_op = dout.alu_op;
  assign out_left = dout.left;
  assign out_right = dout.right;
  assign out_store_data = dout.store_data;
  assign out_pc = dout.pc;
  assign out_rd = dout.rd;
  assign out_rd_wen = dout.rd_wen;
endmodule

// File: tb/tb_exu_operand_stage.sv
// tb_exu_operand_stage: directed stimulus with a queue scoreboard checked by an output monitor
module tb_exu_operand_stage;
  import exu_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready;
  logic [31:0] in_pc = 0, in_rs1_data = 0, in_rs2_data = 0, in_imm = 0, fwd_data = 0;
  logic [4:0] in_rs1_idx = 0, in_rs2_idx = 0, in_rd = 0, fwd_rd = 0;
  logic in_src1_sel = 0, in_src2_sel = 0, in_rd_wen = 0, fwd_wen = 0;
  logic [3:0] in_alu_op = 0;
  logic out_valid, out_ready = 0, out_rd_wen;
  logic [3:0] out_alu_op;
  logic [31:0] out_left, out_right, out_store_data, out_pc;
  logic [4:0] out_rd;
  int n_cmp = 0, n_err = 0;
  entry_t sb[$];

  exu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_left(out_left), .out_right(out_right),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  always #5 clk = ~clk;

  // monitor: every transfer on the output side must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      entry_t act, exp;
      act = '{alu_op: out_alu_op, left: out_left, right: out_right, store_data: out_store_data,
              pc: out_pc, rd: out_rd, rd_wen: out_rd_wen};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got op=%h left=%h right=%h, required no output", out_alu_op, out_left, out_right);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL issue_pc_%h: got op=%h left=%h right=%h st=%h pc=%h rd=%0d w=%b, required op=%h left=%h right=%h st=%h pc=%h rd=%0d w=%b",
                   exp.pc, act.alu_op, act.left, act.right, act.store_data, act.pc, act.rd, act.rd_wen,
                   exp.alu_op, exp.left, exp.right, exp.store_data, exp.pc, exp.rd, exp.rd_wen);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] r1i,
                       input logic [31:0] r1d, input logic [4:0] r2i, input logic [31:0] r2d,
                       input logic [31:0] imm, input logic s1, input logic s2, input logic [4:0] rd,
                       input logic fw, input logic [4:0] frd, input logic [31:0] fd);
    in_valid = 1; in_alu_op = op; in_pc = pc; in_rs1_idx = r1i; in_rs1_data = r1d;
    in_rs2_idx = r2i; in_rs2_data = r2d; in_imm = imm; in_src1_sel = s1; in_src2_sel = s2;
    in_rd = rd; in_rd_wen = 1; fwd_wen = fw; fwd_rd = frd; fwd_data = fd;
  endtask

  // issue one instruction; exp_* are the hand-computed operand values
  task automatic send(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] r1i,
                      input logic [31:0] r1d, input logic [4:0] r2i, input logic [31:0] r2d,
                      input logic [31:0] imm, input logic s1, input logic s2, input logic [4:0] rd,
                      input logic fw, input logic [4:0] frd, input logic [31:0] fd,
                      input logic [31:0] el, input logic [31:0] er, input logic [31:0] es);
    drive(op, pc, r1i, r1d, r2i, r2d, imm, s1, s2, rd, fw, frd, fd);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout_pc_%h: got in_ready=0, required 1 within 50 cycles", pc);
    end else
      sb.push_back('{alu_op: op, left: el, right: er, store_data: es, pc: pc, rd: rd, rd_wen: 1'b1});
    @(posedge clk); #1;
    in_valid = 0; fwd_wen = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    rst_n = 1;
    #1;
    check("reset_out_left", out_left, 0);
    check("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    // addi: rs1 + imm
    send(ALU_OP_ADD, 32'h100, 1, 5, 2, 9, 7, SRC1_RS1, SRC2_IMM, 4, 0, 0, 0, 5, 7, 9);
    check("single_out_valid", 32'(out_valid), 1);
    drain();
    // forwarding on rs1, x0 suppression, forwarding on rs2, disabled forward
    send(ALU_OP_ADD, 32'h104, 3, 1, 4, 2, 0, SRC1_RS1, SRC2_RS2, 5, 1, 3, 32'h55, 32'h55, 2, 2);
    send(ALU_OP_ADD, 32'h108, 0, 1, 0, 32'h22, 0, SRC1_RS1, SRC2_RS2, 6, 1, 0, 32'h55, 1, 32'h22, 32'h22);
    send(ALU_OP_SUB, 32'h10c, 5, 10, 6, 20, 0, SRC1_RS1, SRC2_RS2, 7, 1, 6, 32'haa, 10, 32'haa, 32'haa);
    send(ALU_OP_SLT, 32'h110, 7, 32'h77, 8, 3, 0, SRC1_RS1, SRC2_RS2, 8, 0, 7, 32'h99, 32'h77, 3, 3);
    // auipc
    send(ALU_OP_ADD, 32'h80000000, 1, 5, 2, 9, 32'h1000, SRC1_PC, SRC2_IMM, 9, 0, 0, 0, 32'h80000000, 32'h1000, 9);
    drain();
    // backpressure: A and B fill the stage, C waits until the ALU side drains
    out_ready = 0;
    send(ALU_OP_AND, 32'h200, 1, 32'hf0, 2, 32'h3c, 0, SRC1_RS1, SRC2_RS2, 10, 0, 0, 0, 32'hf0, 32'h3c, 32'h3c);
    send(ALU_OP_OR, 32'h204, 3, 32'h11, 4, 32'h22, 0, SRC1_RS1, SRC2_RS2, 11, 0, 0, 0, 32'h11, 32'h22, 32'h22);
    check("full_in_ready", 32'(in_ready), 0);
    fork
      send(ALU_OP_XOR, 32'h208, 5, 32'h33, 6, 32'h44, 32'h8, SRC1_RS1, SRC2_IMM, 12, 0, 0, 0, 32'h33, 32'h8, 32'h44);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_out_left", out_left, 32'hf0);
        out_ready = 1;
      end
    join
    drain();
    check("drained_out_valid", 32'(out_valid), 0);
    // flush while FULL with a pending input
    out_ready = 0;
    send(ALU_OP_SLL, 32'h300, 1, 1, 2, 2, 0, SRC1_RS1, SRC2_RS2, 13, 0, 0, 0, 1, 2, 2);
    send(ALU_OP_SRL, 32'h304, 1, 3, 2, 4, 0, SRC1_RS1, SRC2_RS2, 14, 0, 0, 0, 3, 4, 4);
    drive(ALU_OP_SRA, 32'h308, 1, 5, 2, 6, 0, SRC1_RS1, SRC2_RS2, 15, 0, 0, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    check("flush_full_out_valid", 32'(out_valid), 0);
    check("flush_full_in_ready", 32'(in_ready), 1);
    // flush in ONE with an accept in the same cycle: the new entry is dropped
    send(ALU_OP_SLTU, 32'h400, 1, 7, 2, 8, 0, SRC1_RS1, SRC2_RS2, 16, 0, 0, 0, 7, 8, 8);
    drive(ALU_OP_ADD, 32'h404, 1, 9, 2, 10, 0, SRC1_RS1, SRC2_RS2, 17, 0, 0, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    out_ready = 1;
    check("flush_accept_out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk); #1;
    check("flush_accept_dropped", 32'(out_valid), 0);
    // asynchronous reset mid-cycle while FULL
    out_ready = 0;
    send(ALU_OP_AND, 32'h500, 1, 32'h5a, 2, 32'ha5, 0, SRC1_RS1, SRC2_RS2, 18, 0, 0, 0, 32'h5a, 32'ha5, 32'ha5);
    send(ALU_OP_OR, 32'h504, 1, 32'h6b, 2, 32'hb6, 0, SRC1_RS1, SRC2_RS2, 19, 0, 0, 0, 32'h6b, 32'hb6, 32'hb6);
    #2 rst_n = 0;
    #1;
    sb.delete();
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_left", out_left, 0);
    check("async_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (3) @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 0);
    // stage still works after reset
    send(ALU_OP_XOR, 32'h600, 2, 32'h12, 3, 32'h34, 0, SRC1_RS1, SRC2_RS2, 20, 1, 3, 32'h56, 32'h12, 32'h56, 32'h56);
    drain();
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
